// File: rtl/hb_decim2_out_pkg.sv
// Shared DSP package: 1s17 sample type, its limits and the
// shift-with-overflow helpers used by the decimator gain stage.
package dsp_pkg;

  localparam int SAMPLE_W  = 18;
  localparam int MAX_SHIFT = 3;

  typedef logic signed [SAMPLE_W-1:0]           sample_t;
  typedef logic signed [SAMPLE_W+MAX_SHIFT-1:0] sample_ext_t;

  localparam sample_t SAMPLE_MAX = 18'sh1FFFF;
  localparam sample_t SAMPLE_MIN = 18'sh20000;

  // Sign-extend to the widest legal shift and apply the gain.
  function automatic sample_ext_t shift_ext(input sample_t x, input int unsigned sh);
    sample_ext_t e;
    e = sample_ext_t'(x);
    return e <<< sh;
  endfunction

  // True when the bits above the 1s17 result are not a sign extension of it.
  function automatic logic shift_ovf(input sample_t x, input int unsigned sh);
    sample_ext_t e;
    e = shift_ext(x, sh);
    return !((&e[SAMPLE_W+MAX_SHIFT-1:SAMPLE_W-1]) || !(|e[SAMPLE_W+MAX_SHIFT-1:SAMPLE_W-1]));
  endfunction

  // Shift and clamp to the 1s17 range on overflow, by the sign of the input.
  function automatic sample_t sat_shift(input sample_t x, input int unsigned sh);
    sample_ext_t e;
    e = shift_ext(x, sh);
    if (shift_ovf(x, sh)) begin
      return x[SAMPLE_W-1] ? SAMPLE_MIN : SAMPLE_MAX;
    end
    return e[SAMPLE_W-1:0];
  endfunction

  // Shift and keep the low bits (two's-complement wrap).
  function automatic sample_t wrap_shift(input sample_t x, input int unsigned sh);
    sample_ext_t e;
    e = shift_ext(x, sh);
    return e[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/hb_decim2_out_if.sv
// Valid/ready sample stream leaving the decimator towards the next consumer.
interface hb_decim2_out_if
  import dsp_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
);
  logic signed [WIDTH-1:0] y_out;
  logic                    y_valid;
  logic                    y_ready;

  modport master (output y_out, output y_valid, input  y_ready);
  modport slave  (input  y_out, input  y_valid, output y_ready);
endinterface

// File: rtl/hb_decim2_out_sync_fifo_sa.sv
// Show-ahead synchronous FIFO. The head entry is presented whenever the FIFO
// is non-empty; a push into a full FIFO only succeeds if a pop happens in the
// same cycle, otherwise it is discarded and reported on o_drop for one cycle.
module sync_fifo_sa
  import dsp_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_ready,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_ready & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_drop  = i_push & w_full & ~w_pop;

  // Storage and write pointer; contents are cleared so nothing stale survives reset.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
      r_wr_ptr        <= r_wr_ptr + PW'(1);
    end
  end

  // Read pointer advances on every accepted handshake.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Occupancy tracks push/pop; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid = ~w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/hb_decim2_out.sv
// Decimate-by-2 output stage behind the second halfband filter.
// Keeps one sample in two (phase realigned on sam_clk_en), applies a
// power-of-two gain with sticky overflow, and buffers into a show-ahead FIFO.
// Optional feature macro: HB_DECIM2_SAT_EN (saturate on gain overflow
// instead of wrapping).
// WIDTH is expected to match dsp_pkg::SAMPLE_W; GAIN_SHIFT must be 0..3.
module hb_decim2_out
  import dsp_pkg::*;
#(
  parameter int          WIDTH      = SAMPLE_W,
  parameter int unsigned GAIN_SHIFT = 1,
  parameter int          DEPTH      = 4
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   sam_clk_en,
  input  logic                   sys_clk2_en,
  input  logic [WIDTH-1:0]       x_in,
  input  logic                   phase_sel,
  hb_decim2_out_if.master        y_bus,
  output logic                   ovf,
  output logic                   drop,
  output logic [$clog2(DEPTH):0] count
);

  logic             r_ph;
  logic             r_g_vld;
  logic [WIDTH-1:0] r_g_data;
  logic             r_ovf;
  logic             r_drop;

  logic             w_capture;
  logic [WIDTH-1:0] w_gain;
  logic             w_gain_ovf;
  logic             w_fifo_drop;
  logic [WIDTH-1:0] w_fifo_data;
  logic             w_fifo_valid;

  assign w_capture  = sys_clk2_en & (r_ph == phase_sel);
  assign w_gain_ovf = shift_ovf(sample_t'(x_in), GAIN_SHIFT);

`ifdef HB_DECIM2_SAT_EN
  assign w_gain = WIDTH'(sat_shift(sample_t'(x_in), GAIN_SHIFT));
`else
  assign w_gain = WIDTH'(wrap_shift(sample_t'(x_in), GAIN_SHIFT));
`endif

  // Phase bit: forced to 0 on the sample strobe, otherwise toggles on each 2x strobe.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_ph <= 1'b0;
    end else if (sys_clk2_en) begin
      r_ph <= sam_clk_en ? 1'b0 : ~r_ph;
    end
  end

  // Gain stage register: holds the scaled kept sample for one-cycle push into the FIFO.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_g_vld  <= 1'b0;
      r_g_data <= '0;
    end else begin
      r_g_vld <= w_capture;
      if (w_capture) begin
        r_g_data <= w_gain;
      end
    end
  end

  // Sticky flags: gain overflow on a kept sample, and any push lost to a full FIFO.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (w_capture && w_gain_ovf) begin
        r_ovf <= 1'b1;
      end
      if (w_fifo_drop) begin
        r_drop <= 1'b1;
      end
    end
  end

  sync_fifo_sa #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .reset   (reset),
    .i_push  (r_g_vld),
    .i_data  (r_g_data),
    .i_ready (y_bus.y_ready),
    .o_data  (w_fifo_data),
    .o_valid (w_fifo_valid),
    .o_count (count),
    .o_drop  (w_fifo_drop)
  );

  assign y_bus.y_out   = w_fifo_data;
  assign y_bus.y_valid = w_fifo_valid;
  assign ovf           = r_ovf;
  assign drop          = r_drop;

endmodule

// File: tb/tb_hb_decim2_out.sv
// Testbench for hb_decim2_out: directed strobe patterns plus randomized
// traffic, checked by a scoreboard fed from a behavioural reference model.
module tb_hb_decim2_out;
  import dsp_pkg::*;

  localparam int WIDTH = 18;
  localparam int GS    = 1;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam longint SMAX = 131071;
  localparam longint SMIN = -131072;

  logic                    sys_clk = 1'b0;
  logic                    reset;
  logic                    samClkEn;
  logic                    sysClk2En;
  logic signed [WIDTH-1:0] xIn;
  logic                    phaseSel;
  logic                    ovf;
  logic                    drop;
  logic [CW-1:0]           count;

  hb_decim2_out_if #(.WIDTH(WIDTH)) yBus ();

  hb_decim2_out #(
    .WIDTH      (WIDTH),
    .GAIN_SHIFT (GS),
    .DEPTH      (DEPTH)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .sam_clk_en  (samClkEn),
    .sys_clk2_en (sysClk2En),
    .x_in        (xIn),
    .phase_sel   (phaseSel),
    .y_bus       (yBus),
    .ovf         (ovf),
    .drop        (drop),
    .count       (count)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model state and scoreboard
  int                      checks = 0;
  int                      errors = 0;
  bit                      mPh;
  bit                      mGvld;
  logic signed [WIDTH-1:0] mGdata;
  int                      mCount;
  bit                      mOvf;
  bit                      mDrop;
  logic signed [WIDTH-1:0] expQ[$];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Gain computed with plain integer arithmetic on the real value.
  function automatic logic signed [WIDTH-1:0] gainModel(input logic signed [WIDTH-1:0] x,
                                                         output bit o);
    longint v;
    logic [63:0] vb;
    v  = longint'(x) * (longint'(1) << GS);
    o  = (v > SMAX) || (v < SMIN);
`ifdef HB_DECIM2_SAT_EN
    if (v > SMAX) return 18'sh1FFFF;
    if (v < SMIN) return 18'sh20000;
`endif
    vb = v;
    return vb[WIDTH-1:0];
  endfunction

  task automatic modelClear();
    mPh    = 1'b0;
    mGvld  = 1'b0;
    mGdata = '0;
    mCount = 0;
    mOvf   = 1'b0;
    mDrop  = 1'b0;
    expQ.delete();
  endtask

  // Effect of one rising edge given the inputs currently applied.
  task automatic modelEdge();
    bit pop;
    bit cap;
    bit o;
    pop = (mCount > 0) && yBus.y_ready;
    if (mGvld) begin
      if (mCount < DEPTH || pop) begin
        expQ.push_back(mGdata);
        mCount++;
      end else begin
        mDrop = 1'b1;
      end
    end
    if (pop) mCount--;
    cap = sysClk2En && (mPh == phaseSel);
    if (cap) begin
      mGdata = gainModel(xIn, o);
      if (o) mOvf = 1'b1;
    end
    mGvld = cap;
    if (sysClk2En) mPh = samClkEn ? 1'b0 : ~mPh;
  endtask

  task automatic applyStimulus(input bit sam, input bit clk2, input logic signed [WIDTH-1:0] x,
                               input bit psel, input bit rdy);
    samClkEn     = sam;
    sysClk2En    = clk2;
    xIn          = x;
    phaseSel     = psel;
    yBus.y_ready = rdy;
    @(posedge sys_clk);
    if (!reset) modelEdge();
    #1;
  endtask

  // Monitor: compares DUT outputs against the model mid-cycle, popping on handshakes.
  always @(negedge sys_clk) begin
    if (!reset) begin
      checkOutput("count", longint'(count), longint'(mCount));
      checkOutput("ovf", longint'(ovf), longint'(mOvf));
      checkOutput("drop", longint'(drop), longint'(mDrop));
      checkOutput("y_valid", longint'(yBus.y_valid), longint'(mCount > 0));
      if (mCount > 0) begin
        if (expQ.size() > 0) begin
          checkOutput("y_out", longint'(yBus.y_out), longint'(expQ[0]));
          if (yBus.y_ready) void'(expQ.pop_front());
        end else begin
          checkOutput("scoreboard_empty", longint'(expQ.size()), longint'(mCount));
        end
      end else begin
        checkOutput("y_out_empty", longint'(yBus.y_out), 0);
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_y_valid"}, longint'(yBus.y_valid), 0);
    checkOutput({tag, "_y_out"}, longint'(yBus.y_out), 0);
    checkOutput({tag, "_count"}, longint'(count), 0);
    checkOutput({tag, "_ovf"}, longint'(ovf), 0);
    checkOutput({tag, "_drop"}, longint'(drop), 0);
  endtask

  // Regular strobe pattern: 2x strobe every 4 cycles, sample strobe every 8.
  task automatic runPattern(input int n, input bit psel, input bit rdy, input bit countUp,
                            input logic signed [WIDTH-1:0] xFixed, input bit extraStrobe);
    logic signed [WIDTH-1:0] xv;
    bit clk2;
    xv = 1;
    for (int c = 0; c < n; c++) begin
      clk2 = (c % 4 == 0) || (extraStrobe && (c % 8 == 6));
      applyStimulus(c % 8 == 0, clk2, countUp ? xv : xFixed, psel, rdy);
      if (clk2) xv = xv + 1;
    end
  endtask

  initial begin
    bit reached;
    reset        = 1'b0;
    samClkEn     = 1'b0;
    sysClk2En    = 1'b0;
    xIn          = '0;
    phaseSel     = 1'b0;
    yBus.y_ready = 1'b0;
    modelClear();
    #2 reset = 1'b1;
    @(posedge sys_clk);
    #1;
    checkResetValues("por");
    reset = 1'b0;

    // Basic decimation, both phases
    runPattern(64, 1'b0, 1'b1, 1'b1, '0, 1'b0);
    runPattern(64, 1'b1, 1'b1, 1'b1, '0, 1'b0);

    // Gain: in-range value first, then one that overflows
    runPattern(16, 1'b0, 1'b1, 1'b0, 18'sh08000, 1'b0);
    runPattern(16, 1'b0, 1'b1, 1'b0, 18'sh10000, 1'b0);
    runPattern(16, 1'b0, 1'b1, 1'b0, -18'sh0C000, 1'b0);

    // Back-pressure: fill past full, then drain
    runPattern(48, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    runPattern(48, 1'b0, 1'b1, 1'b1, '0, 1'b0);

    // Full with a pop on exactly the write cycle
    runPattern(40, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    for (int c = 0; c < 32; c++) begin
      applyStimulus(c % 8 == 0, c % 4 == 0, 18'(c * 7), 1'b0, mGvld);
    end
    runPattern(24, 1'b0, 1'b1, 1'b0, '0, 1'b0);

    // Phase resync with an extra 2x strobe between sample strobes
    runPattern(48, 1'b0, 1'b1, 1'b1, '0, 1'b1);
    runPattern(48, 1'b1, 1'b1, 1'b1, '0, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      bit clk2;
      clk2 = ($urandom_range(1, 0) == 1);
      if ($urandom_range(31, 0) == 0) phaseSel = ~phaseSel;
      applyStimulus(clk2 && ($urandom_range(3, 0) == 0), clk2, WIDTH'($urandom),
                    phaseSel, $urandom_range(3, 0) != 0);
    end

    // Drain, then build up count 3 with ovf set and reset between edges
    runPattern(16, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int c = 0; c < 8; c++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    reached = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      applyStimulus(c % 8 == 0, c % 4 == 0, 18'sh10000, 1'b0, 1'b0);
      reached = (mCount == 3) && mOvf;
    end
    checkOutput("reset_setup_reached", longint'(reached), 1);
    #2 reset = 1'b1;
    #1;
    checkResetValues("async");
    modelClear();
    applyStimulus(1'b1, 1'b1, 18'sh00123, 1'b0, 1'b1);
    checkResetValues("held");
    reset = 1'b0;
    runPattern(48, 1'b0, 1'b1, 1'b1, '0, 1'b0);

    for (int c = 0; c < 16; c++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("leftover", longint'(expQ.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
